uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DBIT_MAX, default 8: maximum data bits per frame; legal range 5..8.
REQ-002 Parameter OVS, default 16: s_tick pulses per bit period; legal range 8..16.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 s_tick  input  1  oversampling enable pulse, one clk wide, from the external baud generator.
REQ-006 tx_data  input  DBIT_MAX  frame payload; LSB is sent first.
REQ-007 tx_valid  input  1  payload valid.
REQ-008 tx_ready  output  1  block is ready to accept a frame.
REQ-009 cfg_dbits  input  2  data length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-010 cfg_parity  input  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
REQ-011 cfg_stop2  input  1  stop length: 0=one stop bit, 1=two stop bits.
REQ-012 tx  output  1  serial line; idles high.
REQ-013 tx_busy  output  1  high while a frame is in flight.
REQ-014 tx_done_tick  output  1  one-clk pulse at frame completion.

Function
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 tx_ready SHALL be 1 only in IDLE.
REQ-017 Transfer rule: a frame is accepted when tx_valid and tx_ready are both 1 on a clk edge.
REQ-018 On accept, the block SHALL latch tx_data, cfg_dbits, cfg_parity and cfg_stop2, then enter START.
REQ-019 Config input changes after accept SHALL NOT affect the frame in flight.
REQ-020 tx SHALL be registered; it drives 0 starting the clk after accept (one-cycle latency).
REQ-021 Each bit period SHALL last exactly OVS s_tick pulses, counted by the tick counter (s_cnt).
REQ-022 s_cnt SHALL advance only on s_tick; the FSM holds state between ticks.
REQ-023 START→DATA on the OVS-th tick; s_cnt and the bit counter SHALL clear.
REQ-024 DATA SHALL shift the latched word right one bit per bit period.
REQ-025 After N bits (N from latched cfg_dbits), DATA SHALL go to PARITY if parity is enabled, else to STOP.
REQ-026 Latched tx_data bits at index ≥ N SHALL be ignored, both in transmission and in parity.
REQ-027 Parity bit: even = XOR of the N data bits; odd = its inverse; one bit period long.
REQ-028 STOP SHALL drive tx=1 for OVS ticks, or 2*OVS ticks when stop2 is latched.
REQ-029 s_cnt width SHALL be $clog2(2*OVS); no overflow is permitted.
REQ-030 On the final STOP tick: tx_done_tick=1 for that one clk, next state IDLE, tx_ready=1 on the following clk.
REQ-031 Minimum frame gap is one clk plus the wait for the next s_tick boundary.
REQ-032 tx_busy SHALL equal (state != IDLE).
REQ-033 tx_valid while busy SHALL be ignored; no queuing, no data corruption.
REQ-034 An out-of-range state SHALL recover to IDLE with tx=1.

Reset
REQ-035 While reset_n=0 at a clk edge: state=IDLE, tx=1, s_cnt=0, bit counter=0, shift register=0, latched config=0.
REQ-036 Reset output values: tx_ready=1 (IDLE), tx_busy=0, tx_done_tick=0.
REQ-037 Reset mid-frame SHALL abort the frame: tx=1 on the next edge, no done pulse.

Structure
REQ-038 Shared package uart_pkg SHALL hold:
- FSM state encoding;
- parity-mode localparams (NONE, EVEN, ODD);
- the cfg_dbits decode function.
REQ-039 One combinational sub-module, uart_parity, SHALL compute masked parity from data, N and mode; it is reused by the future receiver.

Verification
REQ-040 8N1 test: cfg=11/00/0, tx_data=0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 16 ticks; one done pulse.
REQ-041 7E2 test: cfg_dbits=10, parity=01, stop2=1, tx_data=0xFF → 7 data ones, parity bit 1, stop high for 32 ticks; upper data bit not sent.
REQ-042 5O1 test: cfg_dbits=00, parity=10, tx_data=0xE3 → data bits 1,1,0,0,0, parity bit 1.
REQ-043 Busy-accept test: assert tx_valid continuously with data 0xA5 then 0x3C → exactly two frames, in order, with tx_ready low throughout each frame.
REQ-044 Mid-frame test: change cfg during the DATA state, then pulse reset_n=0 for one clk during DATA → tx=1 the next clk, state IDLE, no tx_done_tick; config change has no effect before the reset.
REQ-045 Tick-hold test: s_tick held low for 100 clks mid-bit → tx and state unchanged throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes, latched-config record
// and the data-length decode used by transmitter and (future) receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Code 2'b11 is a second encoding of "no parity"
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef struct packed {
    logic [1:0] dbits;
    logic [1:0] parity;
    logic       stop2;
  } uart_cfg_t;

  function automatic logic [3:0] dbits_decode(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Frame handshake and per-frame configuration between a producer and the
// UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DBIT_MAX = 8
);
  logic [DBIT_MAX-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [1:0]          cfg_dbits;
  logic [1:0]          cfg_parity;
  logic                cfg_stop2;

  modport master (
    output tx_data, tx_valid, cfg_dbits, cfg_parity, cfg_stop2,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, cfg_dbits, cfg_parity, cfg_stop2,
    output tx_ready
  );
endinterface

// File: rtl/uart_parity.sv
// Masked parity over the low n_bits of data; bits at or above n_bits never
// contribute. Purely combinational so the receiver can share it.
module uart_parity
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = 8
) (
  input  logic [DBIT_MAX-1:0] data,
  input  logic [3:0]          n_bits,
  input  logic [1:0]          mode,
  output logic                par_bit,
  output logic                par_en
);
  logic x;

  always_comb begin
    x = 1'b0;
    for (int i = 0; i < DBIT_MAX; i++) begin
      if (i < int'(n_bits)) x = x ^ data[i];
    end
    par_en  = (mode == PAR_EVEN) || (mode == PAR_ODD);
    par_bit = (mode == PAR_ODD) ? ~x : x;
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..8 data bits, none/even/odd parity,
// one or two stop bits, bit timing from an external s_tick oversampling pulse.
//
// state     | meaning
// ST_IDLE   | line high, tx_ready=1, waiting for tx_valid
// ST_START  | start bit (tx=0) for OVS ticks
// ST_DATA   | N data bits, LSB first, OVS ticks each
// ST_PARITY | parity bit for OVS ticks (only when parity enabled)
// ST_STOP   | line high for OVS or 2*OVS ticks, then done pulse
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = 8,
  parameter int OVS      = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_tick,
  uart_tx_cfg_if.slave  bus,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_done_tick
);
  localparam int SW = $clog2(2 * OVS);
  localparam logic [SW-1:0] BIT_LAST   = SW'(OVS - 1);
  localparam logic [SW-1:0] STOP2_LAST = SW'(2 * OVS - 1);

  logic [2:0]          state_q,   state_d;
  logic                tx_q,      tx_d;
  logic [SW-1:0]       s_cnt_q,   s_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [DBIT_MAX-1:0] sh_q,      sh_d;
  logic [DBIT_MAX-1:0] data_q,    data_d;
  uart_cfg_t           cfg_q,     cfg_d;

  logic       done;
  logic       par_bit, par_en;
  logic [3:0] n_bits, n_last;
  logic [SW-1:0] stop_last;

  assign n_bits    = dbits_decode(cfg_q.dbits);
  assign n_last    = n_bits - 4'd1;
  assign stop_last = cfg_q.stop2 ? STOP2_LAST : BIT_LAST;

  // Parity is taken from the unshifted copy so it stays valid while sh_q drains
  uart_parity #(.DBIT_MAX(DBIT_MAX)) u_parity (
    .data    (data_q),
    .n_bits  (n_bits),
    .mode    (cfg_q.parity),
    .par_bit (par_bit),
    .par_en  (par_en)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    cfg_d     = cfg_q;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_valid) begin
          state_d   = ST_START;
          tx_d      = 1'b0;
          s_cnt_d   = '0;
          bit_cnt_d = '0;
          sh_d      = bus.tx_data;
          data_d    = bus.tx_data;
          cfg_d     = '{dbits: bus.cfg_dbits, parity: bus.cfg_parity,
                        stop2: bus.cfg_stop2};
        end
      end

      ST_START: if (s_tick) begin
        if (s_cnt_q == BIT_LAST) begin
          state_d   = ST_DATA;
          s_cnt_d   = '0;
          bit_cnt_d = '0;
          tx_d      = sh_q[0];
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end

      ST_DATA: if (s_tick) begin
        if (s_cnt_q == BIT_LAST) begin
          s_cnt_d = '0;
          if (bit_cnt_q == n_last) begin
            state_d = par_en ? ST_PARITY : ST_STOP;
            tx_d    = par_en ? par_bit : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sh_d      = sh_q >> 1;
            tx_d      = sh_q[1];
          end
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end

      ST_PARITY: if (s_tick) begin
        if (s_cnt_q == BIT_LAST) begin
          state_d = ST_STOP;
          s_cnt_d = '0;
          tx_d    = 1'b1;
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_cnt_q == stop_last) begin
            state_d = ST_IDLE;
            s_cnt_d = '0;
            done    = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        tx_d      = 1'b1;
        s_cnt_d   = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      cfg_q     <= cfg_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign bus.tx_ready = (state_q == ST_IDLE);
  // A frame aborted by reset must never report completion
  assign tx_done_tick = done & reset_n;

endmodule
